// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared opcodes, control-unit state encodings and instruction classes
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] CU_IDLE      = 3'd0;
  localparam logic [2:0] CU_FETCH     = 3'd1;
  localparam logic [2:0] CU_DECODE    = 3'd2;
  localparam logic [2:0] CU_EXECUTE   = 3'd3;
  localparam logic [2:0] CU_MEMORY    = 3'd4;
  localparam logic [2:0] CU_WRITEBACK = 3'd5;
  localparam logic [2:0] CU_RETIRE    = 3'd6;
  localparam logic [2:0] CU_HALT      = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE      = CU_IDLE,
    S_FETCH     = CU_FETCH,
    S_DECODE    = CU_DECODE,
    S_EXECUTE   = CU_EXECUTE,
    S_MEMORY    = CU_MEMORY,
    S_WRITEBACK = CU_WRITEBACK,
    S_RETIRE    = CU_RETIRE,
    S_HALT      = CU_HALT
  } cu_state_e;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_UPPER,
    CLS_JUMP,
    CLS_BRANCH,
    CLS_LOAD,
    CLS_STORE,
    CLS_SYSTEM,
    CLS_ILLEGAL
  } instr_class_e;

endpackage

// File: rtl/opcode_classifier.sv
// rtl/opcode_classifier.sv - combinational opcode[6:0] to instruction-class decode
module opcode_classifier
  import riscv_pkg::*;
(
  input  logic [6:0]   opcode_i,
  output instr_class_e class_o
);

  // Any opcode not listed (including opcode[1:0] != 2'b11) falls to ILLEGAL.
  always_comb begin
    class_o = CLS_ILLEGAL;
    case (opcode_i)
      OP_R, OP_I_ALU:     class_o = CLS_ALU;
      OP_LUI, OP_AUIPC:   class_o = CLS_UPPER;
      OP_JAL, OP_JALR:    class_o = CLS_JUMP;
      OP_BRANCH:          class_o = CLS_BRANCH;
      OP_LOAD:            class_o = CLS_LOAD;
      OP_STORE:           class_o = CLS_STORE;
      OP_SYSTEM:          class_o = CLS_SYSTEM;
      default:            class_o = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multicycle control FSM with registered strobes and retired-instruction counter
module control_unit
  import riscv_pkg::*;
#(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [6:0]           opcode,
  input  logic                 mem_ready,
  output logic                 fetch,
  output logic                 decode,
  output logic                 dm_read_en,
  output logic                 dm_write_en,
  output logic                 rf_write_en,
  output logic                 finished,
  output logic                 halted,
  output logic                 illegal_instr,
  output logic [CNT_WIDTH-1:0] instret
);

  cu_state_e    state_q, state_d;
  logic [6:0]   opcode_q;
  logic [6:0]   cls_src;
  instr_class_e cls;

  // The live opcode is only trusted in DECODE; later states use the latched copy.
  assign cls_src = (state_q == S_DECODE) ? opcode : opcode_q;

  opcode_classifier u_classifier (
    .opcode_i (cls_src),
    .class_o  (cls)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (run) state_d = S_FETCH;
      S_FETCH:     state_d = S_DECODE;
      S_DECODE:    state_d = (cls == CLS_SYSTEM || cls == CLS_ILLEGAL) ? S_HALT : S_EXECUTE;
      S_EXECUTE: begin
        if (cls == CLS_LOAD || cls == CLS_STORE) state_d = S_MEMORY;
        else if (cls == CLS_BRANCH)              state_d = S_RETIRE;
        else                                     state_d = S_WRITEBACK;
      end
      S_MEMORY:    if (mem_ready) state_d = (cls == CLS_LOAD) ? S_WRITEBACK : S_RETIRE;
      S_WRITEBACK: state_d = S_RETIRE;
      S_RETIRE:    state_d = run ? S_FETCH : S_IDLE;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so each one is a flop that is high for its whole state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      opcode_q      <= 7'd0;
      fetch         <= 1'b0;
      decode        <= 1'b0;
      dm_read_en    <= 1'b0;
      dm_write_en   <= 1'b0;
      rf_write_en   <= 1'b0;
      finished      <= 1'b0;
      halted        <= 1'b0;
      illegal_instr <= 1'b0;
      instret       <= '0;
    end else begin
      state_q     <= state_d;
      if (state_q == S_DECODE) opcode_q <= opcode;
      fetch       <= (state_d == S_FETCH);
      decode      <= (state_d == S_DECODE);
      dm_read_en  <= (state_d == S_MEMORY) && (cls == CLS_LOAD);
      dm_write_en <= (state_d == S_MEMORY) && (cls == CLS_STORE);
      rf_write_en <= (state_d == S_WRITEBACK);
      finished    <= (state_d == S_RETIRE);
      halted      <= halted | (state_d == S_HALT);
      if (state_q == S_DECODE && cls == CLS_ILLEGAL) illegal_instr <= 1'b1;
      if (state_q == S_RETIRE) instret <= instret + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed vector bench for control_unit
module tb_control_unit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic [6:0]    opcode;
  logic          mem_ready;
  logic          fetch, decode, dm_read_en, dm_write_en, rf_write_en, finished;
  logic          halted, illegal_instr;
  logic [CW-1:0] instret;

  control_unit #(.CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .fetch         (fetch),
    .decode        (decode),
    .dm_read_en    (dm_read_en),
    .dm_write_en   (dm_write_en),
    .rf_write_en   (rf_write_en),
    .finished      (finished),
    .halted        (halted),
    .illegal_instr (illegal_instr),
    .instret       (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] opc;
    int         waits;
    int         lat;
    int         rd;
    int         wr;
    int         rf;
    bit         halt;
    bit         ill;
  } vec_t;

  vec_t vt[15];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int strobes();
    return int'(fetch) + int'(decode) + int'(dm_read_en) + int'(dm_write_en) +
           int'(rf_write_en) + int'(finished);
  endfunction

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; mem_ready = 1'b1; opcode = 7'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int ff = -1, fin_c = -1, nrd = 0, nwr = 0, nrf = 0, nfin = 0, viol = 0, wl;
    bit next_fetch = 1'b0;
    logic [CW-1:0] ir_after = '0;
    logic [6:0] junk;
    junk = (v.opc == 7'b0000011) ? 7'b1100011 : 7'b0000011;
    do_reset();
    run = 1'b1;
    opcode = junk;
    wl = v.waits;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (strobes() > 1) viol++;
      if (fin_c >= 0) begin
        next_fetch = fetch;
        ir_after = instret;
        break;
      end
      if (fetch && ff < 0) ff = c;
      nrd += int'(dm_read_en);
      nwr += int'(dm_write_en);
      nrf += int'(rf_write_en);
      if (finished) begin
        fin_c = c;
        nfin++;
      end
      opcode = decode ? v.opc : junk;
      if (dm_read_en || dm_write_en) begin
        if (wl > 0) begin
          mem_ready = 1'b0;
          wl--;
        end else mem_ready = 1'b1;
      end else mem_ready = 1'b1;
    end
    n_vec++;
    check($sformatf("v%0d latency", idx), (fin_c < 0) ? 0 : fin_c - ff + 1, v.halt ? 0 : v.lat);
    check($sformatf("v%0d dm_read_en cycles", idx), nrd, v.rd);
    check($sformatf("v%0d dm_write_en cycles", idx), nwr, v.wr);
    check($sformatf("v%0d rf_write_en cycles", idx), nrf, v.rf);
    check($sformatf("v%0d one-hot violations", idx), viol, 0);
    check($sformatf("v%0d halted", idx), halted, v.halt);
    check($sformatf("v%0d illegal_instr", idx), illegal_instr, v.ill);
    if (v.halt) begin
      check($sformatf("v%0d finished count", idx), nfin, 0);
      check($sformatf("v%0d instret", idx), instret, 0);
    end else begin
      check($sformatf("v%0d next fetch", idx), next_fetch, 1);
      check($sformatf("v%0d instret", idx), ir_after, 1);
    end
  endtask

  initial begin
    int cnt, k;
    vt[0]  = '{7'b0110011, 0, 5, 0, 0, 1, 1'b0, 1'b0};
    vt[1]  = '{7'b0010011, 0, 5, 0, 0, 1, 1'b0, 1'b0};
    vt[2]  = '{7'b0110111, 0, 5, 0, 0, 1, 1'b0, 1'b0};
    vt[3]  = '{7'b0010111, 0, 5, 0, 0, 1, 1'b0, 1'b0};
    vt[4]  = '{7'b1101111, 0, 5, 0, 0, 1, 1'b0, 1'b0};
    vt[5]  = '{7'b1100111, 0, 5, 0, 0, 1, 1'b0, 1'b0};
    vt[6]  = '{7'b1100011, 0, 4, 0, 0, 0, 1'b0, 1'b0};
    vt[7]  = '{7'b0000011, 0, 6, 1, 0, 1, 1'b0, 1'b0};
    vt[8]  = '{7'b0000011, 3, 9, 4, 0, 1, 1'b0, 1'b0};
    vt[9]  = '{7'b0100011, 0, 5, 0, 1, 0, 1'b0, 1'b0};
    vt[10] = '{7'b0100011, 2, 7, 0, 3, 0, 1'b0, 1'b0};
    vt[11] = '{7'b1110011, 0, 0, 0, 0, 0, 1'b1, 1'b0};
    vt[12] = '{7'b1111111, 0, 0, 0, 0, 0, 1'b1, 1'b1};
    vt[13] = '{7'b0110001, 0, 0, 0, 0, 0, 1'b1, 1'b1};
    vt[14] = '{7'b0000000, 0, 0, 0, 0, 0, 1'b1, 1'b1};

    rst = 1'b1; run = 1'b0; mem_ready = 1'b1; opcode = 7'd0;
    #1;
    n_vec++;
    check("reset strobes", strobes(), 0);
    check("reset halted/illegal", {halted, illegal_instr}, 0);
    check("reset instret", instret, 0);

    for (int i = 0; i < 15; i++) run_vec(i, vt[i]);

    // rst asserted while a load is stalled in MEMORY
    do_reset();
    run = 1'b1; opcode = 7'b0110011; mem_ready = 1'b1;
    k = 0;
    while (!finished && k < 20) begin @(negedge clk); k++; end
    check("rstmem first retire seen", finished, 1);
    @(negedge clk);
    opcode = 7'b0000011; mem_ready = 1'b0;
    k = 0;
    while (!dm_read_en && k < 20) begin @(negedge clk); k++; end
    n_vec++;
    check("rstmem dm_read_en before rst", dm_read_en, 1);
    check("rstmem instret before rst", instret, 1);
    #2 rst = 1'b1;
    #1;
    check("rstmem dm_read_en after rst", dm_read_en, 0);
    check("rstmem strobes after rst", strobes(), 0);
    check("rstmem instret after rst", instret, 0);
    @(negedge clk);
    rst = 1'b0; run = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    check("rstmem idle after release", strobes(), 0);

    // run dropped during EXECUTE: instruction retires, then IDLE
    do_reset();
    run = 1'b1; opcode = 7'b0110011; mem_ready = 1'b1;
    k = 0;
    while (!decode && k < 20) begin @(negedge clk); k++; end
    @(negedge clk);
    n_vec++;
    check("rundrop idle EXECUTE strobes", strobes(), 0);
    run = 1'b0;
    cnt = 0; k = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      cnt += int'(finished);
      k += int'(fetch);
    end
    check("rundrop finished count", cnt, 1);
    check("rundrop fetch after stop", k, 0);
    check("rundrop instret", instret, 1);

    // 17 retirements wrap a 4-bit counter to 1
    do_reset();
    run = 1'b1; opcode = 7'b0110011; mem_ready = 1'b1;
    cnt = 0; k = 0;
    while (cnt < 17 && k < 120) begin
      @(negedge clk);
      k++;
      if (finished) begin
        cnt++;
        if (cnt == 17) run = 1'b0;
      end
    end
    n_vec++;
    check("wrap retire count", cnt, 17);
    @(negedge clk);
    check("wrap instret", instret, 1);
    @(negedge clk);
    check("wrap idle after stop", strobes(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
